instr_fetch_unit: RTL and testbench
===================================

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 The block SHALL be parameterised as follows:
- DATA_W, 16, instruction width.
- ADDR_W, 16, PC and address width.
- DEPTH, 4, prefetch FIFO entries; power of two, 2..16.
- PC_STEP, 2, PC increment in bytes.
- RESET_PC, 0, PC value after reset.
REQ-002 The block SHALL have the following ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_b  in  1  reset; synchronous, active-low.
- mem_req  out  1  fetch request to memory.
- mem_addr  out  ADDR_W  fetch address.
- mem_ack  in  1  memory returns mem_rdata this cycle.
- mem_rdata  in  DATA_W  fetched instruction.
- redir_valid  in  1  branch/jump redirect strobe.
- redir_pc  in  ADDR_W  redirect target.
- instr_valid  out  1  FIFO head valid.
- instr_data  out  DATA_W  FIFO head instruction.
- instr_pc  out  ADDR_W  address of the head instruction.
- instr_ready  in  1  consumer pops the head when instr_valid=1.
- fill_level  out  $clog2(DEPTH)+1  FIFO occupancy.

Function
REQ-003 The unit SHALL keep an internal fetch PC (fpc) and a FIFO of {instruction, pc} pairs, with show-ahead output: instr_valid=(fill_level!=0), and instr_data/instr_pc driven directly from the head entry.
REQ-004 The FSM SHALL have three states: IDLE (no request outstanding), WAIT (request outstanding), DISCARD (request outstanding whose data is to be dropped).
REQ-005 IDLE SHALL assert mem_req with mem_addr=fpc when redir_valid=0 and fill_level minus pop-this-cycle < DEPTH; state then moves to WAIT.
REQ-006 In WAIT, mem_req SHALL remain 1 and mem_addr SHALL remain stable until mem_ack=1; at most one request SHALL be outstanding.
REQ-007 On mem_ack in WAIT without redirect: push {mem_rdata, fpc}; set fpc to fpc+PC_STEP modulo 2^ADDR_W; go to IDLE. The next request SHALL issue no earlier than the following cycle.
REQ-008 Push and pop in the same cycle SHALL leave fill_level unchanged, and ordering SHALL be preserved.
REQ-009 A pop with instr_valid=0 SHALL be ignored.
REQ-010 A redir_valid in any state SHALL flush the FIFO and load fpc with redir_pc at that edge; instr_valid SHALL be 0 the next cycle.
REQ-011 A redirect while in WAIT without mem_ack SHALL move the FSM to DISCARD.
REQ-012 In DISCARD the FSM SHALL wait for mem_ack, drop the returned data, then go to IDLE.
REQ-013 In DISCARD, mem_req SHALL remain asserted at the old address until mem_ack.
REQ-014 If redir_valid and mem_ack coincide in WAIT, the returned data SHALL be dropped and the FSM SHALL go to IDLE.
REQ-015 If redir_valid and mem_ack coincide in DISCARD, the FSM SHALL go to IDLE with fpc=redir_pc.
REQ-016 A redirect in IDLE SHALL suppress mem_req that cycle.
REQ-017 A pop coinciding with a redirect SHALL be lost to the flush.
REQ-018 A redirect SHALL take priority over push and pop.

Reset
REQ-019 While rst_b=0 at a rising edge, the following SHALL be set: fpc=RESET_PC, FSM=IDLE, FIFO empty, mem_req=0, mem_addr=RESET_PC, instr_valid=0, instr_data=0, instr_pc=0, fill_level=0.
REQ-020 Any mem_ack arriving while reset is applied, or pending at reset mid-request, SHALL be ignored.
REQ-021 The first request SHALL be issued the first cycle after rst_b returns high.

Configuration
REQ-022 With macro FETCH_DROP_COUNT_EN defined, the block SHALL add output drop_cnt (16 bits):
- reset to 0;
- increments by the number of FIFO entries flushed plus 1 for each discarded mem_ack;
- saturates at 16'hFFFF.
REQ-023 Without FETCH_DROP_COUNT_EN, the drop_cnt port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-024 Reset release, mem_ack 1 cycle after each request, instr_ready=1 -> mem_addr sequence 0x0000, 0x0002, 0x0004; instr_pc matches; one instruction per 2 cycles.
REQ-025 instr_ready=0, DEPTH=4, continuous mem_ack -> exactly 4 pushes; fill_level=4; mem_req stays 0; one pop -> exactly one new request.
REQ-026 redir_valid with redir_pc=0x0100 while in WAIT, mem_ack 3 cycles later -> ack data dropped; next mem_addr=0x0100; FIFO empty until that ack; drop_cnt=prior fill+1 (if enabled).
REQ-027 redir_valid and mem_ack in the same cycle, redir_pc=0x0040 -> data not pushed; next mem_addr=0x0040.
REQ-028 fpc=0xFFFE with ack -> next mem_addr=0x0000 (wrap).
REQ-029 rst_b=0 asserted while in WAIT with 3 entries queued -> next cycle fill_level=0, mem_req=0; after release mem_addr=RESET_PC.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction prefetcher: keeps a fetch PC and a show-ahead FIFO of {instr, pc}; one memory request in flight.
// Latency: request issues the cycle after ack at the earliest; pushed data is visible at the head the cycle after ack.
// Backpressure: requests stall while the FIFO would be full; optional drop counter enabled by FETCH_DROP_COUNT_EN.
module instr_fetch_unit #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 16,
  parameter int DEPTH    = 4,
  parameter int PC_STEP  = 2,
  parameter int RESET_PC = 0
) (
  input  logic                      clk,
  input  logic                      rst_b,
  output logic                      mem_req,
  output logic [ADDR_W-1:0]         mem_addr,
  input  logic                      mem_ack,
  input  logic [DATA_W-1:0]         mem_rdata,
  input  logic                      redir_valid,
  input  logic [ADDR_W-1:0]         redir_pc,
  output logic                      instr_valid,
  output logic [DATA_W-1:0]         instr_data,
  output logic [ADDR_W-1:0]         instr_pc,
  input  logic                      instr_ready,
  output logic [$clog2(DEPTH):0]    fill_level
`ifdef FETCH_DROP_COUNT_EN
  ,
  output logic [15:0]               drop_cnt
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0]     DEPTH_C = CW'(DEPTH);
  localparam logic [ADDR_W-1:0] RST_PC  = ADDR_W'(RESET_PC);
  localparam logic [ADDR_W-1:0] STEP    = ADDR_W'(PC_STEP);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DISCARD
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] fpc_q, fpc_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [DATA_W-1:0] dat_q [DEPTH];
  logic [DATA_W-1:0] dat_d [DEPTH];
  logic [ADDR_W-1:0] pcs_q [DEPTH];
  logic [ADDR_W-1:0] pcs_d [DEPTH];

  logic pop;
  logic space;
  logic issue;
  logic push;

`ifdef FETCH_DROP_COUNT_EN
  logic [15:0] drop_q, drop_d;
  logic [CW-1:0] flushed;
  logic          ack_drop;
  logic [17:0]   drop_sum;
`endif

  assign instr_valid = (count_q != '0);
  assign instr_data  = dat_q[rd_ptr_q];
  assign instr_pc    = pcs_q[rd_ptr_q];
  assign fill_level  = count_q;
  assign mem_addr    = addr_q;
  // IDLE request is combinational so a redirect can suppress it in the same cycle.
  assign mem_req     = rst_b && ((state_q != S_IDLE) || issue);

  always_comb begin
    pop   = instr_valid && instr_ready;
    space = (count_q - CW'(pop)) < DEPTH_C;
    issue = (state_q == S_IDLE) && !redir_valid && space;
    push  = (state_q == S_WAIT) && mem_ack && !redir_valid;

    state_d  = state_q;
    fpc_d    = fpc_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    dat_d    = dat_q;
    pcs_d    = pcs_q;

    case (state_q)
      S_IDLE: begin
        if (issue) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (mem_ack)          state_d = S_IDLE;
        else if (redir_valid) state_d = S_DISCARD;
      end
      S_DISCARD: begin
        if (mem_ack) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (redir_valid) begin
      fpc_d    = redir_pc;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        dat_d[wr_ptr_q] = mem_rdata;
        pcs_d[wr_ptr_q] = fpc_q;
        wr_ptr_d        = wr_ptr_q + PW'(1);
        fpc_d           = fpc_q + STEP;
      end
      if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end

    // The address register follows fpc whenever no request is in flight, and freezes otherwise.
    addr_d = (state_d == S_IDLE) ? fpc_d : addr_q;
  end

`ifdef FETCH_DROP_COUNT_EN
  always_comb begin
    flushed  = redir_valid ? count_q : '0;
    ack_drop = mem_ack && (((state_q == S_WAIT) && redir_valid) || (state_q == S_DISCARD));
    drop_sum = 18'(drop_q) + 18'(flushed) + 18'(ack_drop);
    drop_d   = (drop_sum > 18'h0FFFF) ? 16'hFFFF : drop_sum[15:0];
  end

  assign drop_cnt = drop_q;
`endif

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state_q  <= S_IDLE;
      fpc_q    <= RST_PC;
      addr_q   <= RST_PC;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        dat_q[i] <= '0;
        pcs_q[i] <= '0;
      end
`ifdef FETCH_DROP_COUNT_EN
      drop_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      fpc_q    <= fpc_d;
      addr_q   <= addr_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      dat_q    <= dat_d;
      pcs_q    <= pcs_d;
`ifdef FETCH_DROP_COUNT_EN
      drop_q   <= drop_d;
`endif
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit (DEPTH=4, PC_STEP=2, RESET_PC=0); drop_cnt checks only with FETCH_DROP_COUNT_EN.
module tb_instr_fetch_unit;

  logic        clk;
  logic        rst_b;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic        redir_valid;
  logic [15:0] redir_pc;
  logic        instr_valid;
  logic [15:0] instr_data;
  logic [15:0] instr_pc;
  logic        instr_ready;
  logic [2:0]  fill_level;
`ifdef FETCH_DROP_COUNT_EN
  logic [15:0] drop_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;

  instr_fetch_unit #(
    .DATA_W(16), .ADDR_W(16), .DEPTH(4), .PC_STEP(2), .RESET_PC(0)
  ) dut (
    .clk(clk),
    .rst_b(rst_b),
    .mem_req(mem_req),
    .mem_addr(mem_addr),
    .mem_ack(mem_ack),
    .mem_rdata(mem_rdata),
    .redir_valid(redir_valid),
    .redir_pc(redir_pc),
    .instr_valid(instr_valid),
    .instr_data(instr_data),
    .instr_pc(instr_pc),
    .instr_ready(instr_ready),
    .fill_level(fill_level)
`ifdef FETCH_DROP_COUNT_EN
    ,
    .drop_cnt(drop_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_b = 1'b0;
    tick();
    tick();
    rst_b = 1'b1;
    #1;
  endtask

  initial begin
    rst_b       = 1'b0;
    mem_ack     = 1'b0;
    mem_rdata   = '0;
    redir_valid = 1'b0;
    redir_pc    = '0;
    instr_ready = 1'b0;

    // Reset state
    tick();
    tick();
    chk("rst_fill", 32'(fill_level), 0);
    chk("rst_valid", 32'(instr_valid), 0);
    chk("rst_req", 32'(mem_req), 0);
    chk("rst_addr", 32'(mem_addr), 0);
    chk("rst_data", 32'(instr_data), 0);
    chk("rst_pc", 32'(instr_pc), 0);
`ifdef FETCH_DROP_COUNT_EN
    chk("rst_drop", 32'(drop_cnt), 0);
`endif

    // Streaming: ack one cycle after each request, consumer always ready
    instr_ready = 1'b1;
    rst_b = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("strm_req", 32'(mem_req), 1);
      chk("strm_addr", 32'(mem_addr), 32'(2 * i));
      tick();
      mem_ack   = 1'b1;
      mem_rdata = 16'hA000 + 16'(i);
      #1;
      chk("strm_wait_req", 32'(mem_req), 1);
      chk("strm_wait_addr", 32'(mem_addr), 32'(2 * i));
      tick();
      mem_ack = 1'b0;
      #1;
      chk("strm_valid", 32'(instr_valid), 1);
      chk("strm_ipc", 32'(instr_pc), 32'(2 * i));
      chk("strm_data", 32'(instr_data), 32'h0000A000 + 32'(i));
    end

    // Fill to DEPTH with consumer stalled, then pop once
    instr_ready = 1'b0;
    do_reset();
    mem_ack   = 1'b1;
    mem_rdata = 16'hB000;
    repeat (12) tick();
    chk("full_fill", 32'(fill_level), 4);
    chk("full_req", 32'(mem_req), 0);
    chk("full_head", 32'(instr_pc), 0);
    chk("full_addr", 32'(mem_addr), 8);
    instr_ready = 1'b1;
    #1;
    chk("pop_req", 32'(mem_req), 1);
    tick();
    instr_ready = 1'b0;
    #1;
    chk("pop_fill", 32'(fill_level), 3);
    chk("pop_head", 32'(instr_pc), 2);
    tick();
    chk("refill_fill", 32'(fill_level), 4);
    chk("refill_req", 32'(mem_req), 0);
    tick();
    chk("refill_req2", 32'(mem_req), 0);
    // Push and pop on the same edge
    instr_ready = 1'b1;
    tick();
    tick();
    chk("pp_fill", 32'(fill_level), 3);
    chk("pp_head", 32'(instr_pc), 6);
    instr_ready = 1'b0;
    mem_ack     = 1'b0;
    tick();
    instr_ready = 1'b1;
    #1;
    chk("drain_pc6", 32'(instr_pc), 6);
    tick();
    chk("drain_pc8", 32'(instr_pc), 8);
    tick();
    chk("drain_pc10", 32'(instr_pc), 10);
    tick();
    chk("drain_empty", 32'(instr_valid), 0);

    // Redirect while waiting, ack arrives three cycles later
    instr_ready = 1'b0;
    do_reset();
    tick();
    mem_ack   = 1'b1;
    mem_rdata = 16'hC000;
    tick();
    mem_ack = 1'b0;
    tick();
    redir_valid = 1'b1;
    redir_pc    = 16'h0100;
    #1;
    chk("rw_req", 32'(mem_req), 1);
    tick();
    redir_valid = 1'b0;
    #1;
    chk("disc_fill", 32'(fill_level), 0);
    chk("disc_valid", 32'(instr_valid), 0);
    chk("disc_req", 32'(mem_req), 1);
    chk("disc_addr", 32'(mem_addr), 2);
    tick();
    chk("disc_addr2", 32'(mem_addr), 2);
    tick();
    mem_ack   = 1'b1;
    mem_rdata = 16'hDEAD;
    tick();
    mem_ack = 1'b0;
    #1;
    chk("disc_drop_fill", 32'(fill_level), 0);
    chk("disc_next_req", 32'(mem_req), 1);
    chk("disc_next_addr", 32'(mem_addr), 32'h0100);
`ifdef FETCH_DROP_COUNT_EN
    chk("disc_dropcnt", 32'(drop_cnt), 2);
`endif
    tick();
    mem_ack   = 1'b1;
    mem_rdata = 16'h1234;
    tick();
    mem_ack = 1'b0;
    #1;
    chk("redir_head_pc", 32'(instr_pc), 32'h0100);
    chk("redir_head_dat", 32'(instr_data), 32'h1234);
    chk("redir_next_addr", 32'(mem_addr), 32'h0102);

    // Redirect coinciding with ack in WAIT
    tick();
    mem_ack     = 1'b1;
    mem_rdata   = 16'h0BAD;
    redir_valid = 1'b1;
    redir_pc    = 16'h0040;
    tick();
    mem_ack     = 1'b0;
    redir_valid = 1'b0;
    #1;
    chk("coinc_fill", 32'(fill_level), 0);
    chk("coinc_valid", 32'(instr_valid), 0);
    chk("coinc_req", 32'(mem_req), 1);
    chk("coinc_addr", 32'(mem_addr), 32'h0040);
`ifdef FETCH_DROP_COUNT_EN
    chk("coinc_dropcnt", 32'(drop_cnt), 4);
`endif

    // Redirect in IDLE suppresses the request; fetch PC wraps past 0xFFFE
    redir_valid = 1'b1;
    redir_pc    = 16'hFFFE;
    #1;
    chk("idle_redir_req", 32'(mem_req), 0);
    tick();
    redir_valid = 1'b0;
    #1;
    chk("wrap_req", 32'(mem_req), 1);
    chk("wrap_addr0", 32'(mem_addr), 32'hFFFE);
    tick();
    mem_ack   = 1'b1;
    mem_rdata = 16'h5555;
    tick();
    mem_ack = 1'b0;
    #1;
    chk("wrap_head", 32'(instr_pc), 32'hFFFE);
    chk("wrap_next", 32'(mem_addr), 0);

    // Reset while waiting with 3 queued entries and an ack pending
    tick();
    mem_ack   = 1'b1;
    mem_rdata = 16'h6001;
    tick();
    mem_ack = 1'b0;
    tick();
    mem_ack   = 1'b1;
    mem_rdata = 16'h6002;
    tick();
    mem_ack = 1'b0;
    tick();
    chk("pre_rst_fill", 32'(fill_level), 3);
    chk("pre_rst_req", 32'(mem_req), 1);
    rst_b   = 1'b0;
    mem_ack = 1'b1;
    tick();
    chk("mid_rst_fill", 32'(fill_level), 0);
    chk("mid_rst_req", 32'(mem_req), 0);
    chk("mid_rst_valid", 32'(instr_valid), 0);
    chk("mid_rst_addr", 32'(mem_addr), 0);
`ifdef FETCH_DROP_COUNT_EN
    chk("mid_rst_drop", 32'(drop_cnt), 0);
`endif
    tick();
    rst_b   = 1'b1;
    mem_ack = 1'b0;
    #1;
    chk("post_rst_req", 32'(mem_req), 1);
    chk("post_rst_addr", 32'(mem_addr), 0);
    chk("post_rst_fill", 32'(fill_level), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
